// File: rtl/eq_pkg.sv
// Shared constants, band indices and FSM state type for the equalizer band mixer.
package eq_pkg;

  localparam int NUM_BANDS  = 10;
  localparam int DATA_W     = 24;
  localparam int GAIN_W     = 16;
  localparam int GAIN_FRAC  = 12;
  localparam int ACC_W      = DATA_W + GAIN_W + 4;
  localparam int BAND_IDX_W = 4;

  localparam logic signed [GAIN_W-1:0] GAIN_UNITY = 16'sd4096;

  localparam logic [BAND_IDX_W-1:0] BAND_LOWPASS  = 4'd0;
  localparam logic [BAND_IDX_W-1:0] BAND_HIGHPASS = 4'd9;
  localparam logic [BAND_IDX_W-1:0] LAST_BAND     = BAND_IDX_W'(NUM_BANDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } eq_state_t;

endpackage

// File: rtl/eq_gain_table.sv
// Shadow/active per-band gain register file; commit copies shadow to active atomically.
module eq_gain_table
  import eq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [BAND_IDX_W-1:0]   wr_addr,
  input  logic signed [GAIN_W-1:0] wr_data,
  input  logic                    commit,
  input  logic [BAND_IDX_W-1:0]   rd_idx,
  output logic signed [GAIN_W-1:0] rd_gain
);

  logic signed [GAIN_W-1:0] shadow [NUM_BANDS];
  logic signed [GAIN_W-1:0] active [NUM_BANDS];

  // Commit samples the pre-write shadow, so a same-cycle write lands in the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        shadow[i] <= GAIN_UNITY;
        active[i] <= GAIN_UNITY;
      end
    end else begin
      if (wr_en && (wr_addr <= LAST_BAND)) begin
        shadow[wr_addr] <= wr_data;
      end
      if (commit) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  assign rd_gain = (rd_idx <= LAST_BAND) ? active[rd_idx] : '0;

endmodule

// File: rtl/eq_band_mix_scheduler.sv
// Mixes ten band samples through one shared signed MAC with per-band gain, then rounds and saturates.
// Handshake: sample_valid is a one-cycle strobe accepted in IDLE/OUT (dropped with an overrun pulse in MAC); out_valid is a one-cycle strobe with no backpressure.
module eq_band_mix_scheduler
  import eq_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  input  logic [NUM_BANDS*DATA_W-1:0]   band_data,
  input  logic                          gain_wr_en,
  input  logic [BAND_IDX_W-1:0]         gain_wr_addr,
  input  logic signed [GAIN_W-1:0]      gain_wr_data,
  output logic signed [DATA_W-1:0]      out_sample,
  output logic                          out_valid,
  output logic                          sat,
  output logic                          busy,
  output logic                          overrun
);

  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(2 ** (GAIN_FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  eq_state_t                state, state_n;
  logic                     capture;
  logic                     overrun_n;
  logic [BAND_IDX_W-1:0]    idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] bands [NUM_BANDS];
  logic signed [DATA_W-1:0] cur_band;
  logic signed [GAIN_W-1:0] cur_gain;
  logic signed [ACC_W-1:0]  ext_band, ext_gain, prod;
  logic signed [ACC_W-1:0]  acc_rnd, shifted;
  logic                     clip_hi, clip_lo;
  logic signed [DATA_W-1:0] sat_val;

  eq_gain_table u_gain_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (gain_wr_en),
    .wr_addr (gain_wr_addr),
    .wr_data (gain_wr_data),
    .commit  (capture),
    .rd_idx  (idx),
    .rd_gain (cur_gain)
  );

  always_comb begin
    state_n   = state;
    capture   = 1'b0;
    overrun_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sample_valid) begin
          capture = 1'b1;
          state_n = ST_MAC;
        end
      end
      ST_MAC: begin
        overrun_n = sample_valid;
        if (idx == LAST_BAND) state_n = ST_OUT;
      end
      ST_OUT: begin
        if (sample_valid) begin
          capture = 1'b1;
          state_n = ST_MAC;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Size casts of signed operands sign-extend, giving a full-precision product.
  assign cur_band = bands[idx];
  assign ext_band = ACC_W'(cur_band);
  assign ext_gain = ACC_W'(cur_gain);
  assign prod     = ext_band * ext_gain;

  assign acc_rnd = acc + ROUND_BIAS;
  assign shifted = acc_rnd >>> GAIN_FRAC;
  assign clip_hi = shifted > SAT_MAX;
  assign clip_lo = shifted < SAT_MIN;
  assign sat_val = clip_hi ? SAT_MAX[DATA_W-1:0] :
                   clip_lo ? SAT_MIN[DATA_W-1:0] : shifted[DATA_W-1:0];

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      idx        <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      sat        <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) bands[i] <= '0;
    end else begin
      state     <= state_n;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      overrun   <= overrun_n;
      if (state == ST_OUT) begin
        out_sample <= sat_val;
        out_valid  <= 1'b1;
        sat        <= clip_hi | clip_lo;
      end
      if (capture) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          bands[i] <= band_data[i*DATA_W +: DATA_W];
        end
        acc <= '0;
        idx <= '0;
      end else if (state == ST_MAC) begin
        acc <= acc + prod;
        idx <= (idx == LAST_BAND) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eq_band_mix_scheduler.sv
// Scoreboard bench for the band mixer: driver models gain commit and acceptance, monitor checks outputs.
module tb_eq_band_mix_scheduler;
  import eq_pkg::*;

  typedef int band_arr_t [NUM_BANDS];

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          sample_valid = 1'b0;
  logic [NUM_BANDS*DATA_W-1:0]   band_data = '0;
  logic                          gain_wr_en = 1'b0;
  logic [BAND_IDX_W-1:0]         gain_wr_addr = '0;
  logic signed [GAIN_W-1:0]      gain_wr_data = '0;
  logic signed [DATA_W-1:0]      out_sample;
  logic                          out_valid, sat, busy, overrun;

  eq_band_mix_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .band_data    (band_data),
    .gain_wr_en   (gain_wr_en),
    .gain_wr_addr (gain_wr_addr),
    .gain_wr_data (gain_wr_data),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .sat          (sat),
    .busy         (busy),
    .overrun      (overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0] exp_q [$];
  int              due_q [$];
  int              ovr_q [$];
  int              shadow [NUM_BANDS];
  int              last_cap = -1000;
  int              tests = 0;
  int              fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic band_arr_t all_of(input int v);
    band_arr_t b;
    for (int i = 0; i < NUM_BANDS; i++) b[i] = v;
    return b;
  endfunction

  // Reference: weighted sum with committed gains, round half up, clamp to 24-bit.
  task automatic model_capture(input band_arr_t b);
    longint s = 0;
    longint r;
    logic   clipped;
    logic [DATA_W:0] e;
    for (int i = 0; i < NUM_BANDS; i++) s += longint'(b[i]) * longint'(shadow[i]);
    r = (s + 2048) >>> 12;
    clipped = 1'b0;
    if (r > 8388607)  begin r = 8388607;  clipped = 1'b1; end
    if (r < -8388608) begin r = -8388608; clipped = 1'b1; end
    e = {clipped, r[DATA_W-1:0]};
    exp_q.push_back(e);
    due_q.push_back(cyc + NUM_BANDS + 2);
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit sv, input band_arr_t b, input bit we,
                             input int wa, input int wd);
    sample_valid = sv;
    gain_wr_en   = we;
    gain_wr_addr = wa[BAND_IDX_W-1:0];
    gain_wr_data = wd[GAIN_W-1:0];
    for (int i = 0; i < NUM_BANDS; i++) band_data[i*DATA_W +: DATA_W] = b[i][DATA_W-1:0];
    if (sv) begin
      if (cyc - last_cap >= NUM_BANDS + 1) begin
        model_capture(b);
        last_cap = cyc;
      end else begin
        ovr_q.push_back(cyc + 1);
      end
    end
    if (we && wa < NUM_BANDS) shadow[wa] = wd;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    gain_wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, all_of(0), 1'b0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    drive_cycle(1'b0, all_of(0), 1'b1, a, d);
  endtask

  task automatic send(input band_arr_t b);
    drive_cycle(1'b1, b, 1'b0, 0, 0);
  endtask

  task automatic set_gains(input int sel, input int g_sel, input int g_other);
    for (int i = 0; i < NUM_BANDS; i++) wr(i, (i == sel) ? g_sel : g_other);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    exp_q.delete();
    due_q.delete();
    ovr_q.delete();
    for (int i = 0; i < NUM_BANDS; i++) shadow[i] = 4096;
    last_cap = -1000;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          logic [DATA_W:0] e;
          int              d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          check("out_sample", longint'(out_sample), longint'($signed(e[DATA_W-1:0])));
          check("sat", longint'(sat), longint'(e[DATA_W]));
          check("out_latency_cycle", cyc, d);
        end
      end else if (sat) begin
        check("sat_without_valid", 1, 0);
      end
      if (overrun) begin
        if (ovr_q.size() == 0) check("unexpected_overrun", 1, 0);
        else check("overrun_cycle", cyc, ovr_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    band_arr_t b;
    int        k;
    int        gap;
    int        nw;

    apply_reset(3);
    check("rst_out_sample", longint'(out_sample), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_sat", longint'(sat), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_overrun", longint'(overrun), 0);

    // Unity gains, all bands 1000.
    send(all_of(1000));
    check("busy_in_mac", longint'(busy), 1);
    idle(14);
    check("busy_idle", longint'(busy), 0);

    // Single band with gain 2.0, others zeroed.
    set_gains(3, 8192, 0);
    b = all_of(7777);
    b[3] = -5000;
    send(b);
    idle(14);

    // Saturation at both rails.
    set_gains(0, 4096, 4096);
    send(all_of(8388607));
    idle(12);
    send(all_of(-8388608));
    idle(14);

    // Rounding with gain 0.5 on band 0.
    set_gains(0, 2048, 0);
    b = all_of(12345); b[0] = 3;  send(b); idle(12);
    b = all_of(12345); b[0] = -3; send(b); idle(12);
    b = all_of(12345); b[0] = 1;  send(b); idle(14);

    // Gain write during MAC affects only the next sample; write at capture is deferred.
    set_gains(0, 4096, 4096);
    send(all_of(100));
    idle(3);
    wr(0, 0);
    idle(8);
    drive_cycle(1'b1, all_of(100), 1'b1, 0, 4096);
    idle(12);
    send(all_of(100));
    idle(14);

    // Out-of-range address is ignored.
    wr(12, 0);
    send(all_of(10));
    idle(14);

    // Overrun mid-MAC, then back-to-back capture in the OUT cycle.
    send(all_of(1000));
    idle(4);
    send(all_of(-2222));
    idle(5);
    send(all_of(50));
    idle(14);

    // Reset mid-MAC aborts the sum and restores unity gains.
    wr(2, 0);
    send(all_of(1000));
    idle(4);
    apply_reset(2);
    check("busy_after_reset", longint'(busy), 0);
    idle(15);
    send(all_of(1000));
    idle(14);

    // Randomized traffic: gain writes, gaps that may land inside MAC, random band data.
    for (int it = 0; it < 40; it++) begin
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 11), int'($urandom) >>> 16);
        else wr($urandom_range(0, 11), int'($urandom_range(0, 8192)) - 4096);
      end
      for (int i = 0; i < NUM_BANDS; i++) begin
        case ($urandom_range(0, 3))
          0: b[i] = int'($urandom) >>> 8;
          1: b[i] = 8388607;
          2: b[i] = -8388608;
          default: b[i] = int'($urandom_range(0, 2000)) - 1000;
        endcase
      end
      gap = $urandom_range(0, 14);
      idle(gap);
      if ($urandom_range(0, 3) == 0)
        drive_cycle(1'b1, b, 1'b1, $urandom_range(0, 9), int'($urandom) >>> 16);
      else
        send(b);
    end

    k = 0;
    while ((exp_q.size() != 0 || ovr_q.size() != 0) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("pending_outputs", exp_q.size(), 0);
    check("pending_overruns", ovr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
